// File: rtl/operand_fetch_pkg.sv
// Shared types and helpers for the 8086 operand fetch sequencer.
// Holds the FSM state encoding, the imm_size encodings and the displacement-length decode.
package operand_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MODRM = 3'd1,
        DISP  = 3'd2,
        IMM   = 3'd3,
        DONE  = 3'd4
    } fetch_state_e;

    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_8    = 2'd1;
    localparam logic [1:0] IMM_16   = 2'd2;

    // mod=00 with rm=110 is the direct-address form and carries a 16-bit displacement.
    function automatic logic [1:0] disp_bytes(input logic [7:0] modrm);
        logic [1:0] len;
        case (modrm[7:6])
            2'b11:   len = 2'd0;
            2'b01:   len = 2'd1;
            2'b10:   len = 2'd2;
            default: len = (modrm[2:0] == 3'b110) ? 2'd2 : 2'd0;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] imm_bytes(input logic [1:0] imm_size);
        logic [1:0] len;
        case (imm_size)
            IMM_8:   len = 2'd1;
            IMM_16:  len = 2'd2;
            default: len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/operand_byte_assembler.sv
// Little-endian collector for a 1- or 2-byte operand field with sign extension of 8-bit values.
// value_o is the assembled field including the byte presented this cycle, so it is meaningful on the final capture.
module operand_byte_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        capture_i,
    input  logic        wide_i,
    input  logic [7:0]  data_i,
    output logic [1:0]  count_o,
    output logic [15:0] value_o
);

    logic [7:0] low_q;
    logic [1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            low_q   <= 8'h00;
            count_q <= 2'd0;
        end else if (clear_i) begin
            low_q   <= 8'h00;
            count_q <= 2'd0;
        end else if (capture_i) begin
            if (count_q == 2'd0) begin
                low_q <= data_i;
            end
            count_q <= count_q + 2'd1;
        end
    end

    assign count_o = count_q;
    assign value_o = wide_i ? {data_i, low_q} : {{8{data_i[7]}}, data_i};

endmodule

// File: rtl/operand_fetch_sequencer.sv
// Fetches ModRM, displacement and immediate bytes from the prefetch FIFO for the 8086 core.
// A byte popped in one cycle is captured in the next; the next field's first pop overlaps that capture.
module operand_fetch_sequencer
    import operand_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic        has_modrm_i,
    input  logic [1:0]  imm_size_i,
    output logic        busy_o,
    output logic        complete_o,
    output logic [7:0]  modrm_o,
    output logic [15:0] displacement_o,
    output logic [15:0] immediate_o,
    output logic        fifo_rd_en_o,
    input  logic [7:0]  fifo_rd_data_i,
    input  logic        fifo_empty_i
);

    fetch_state_e state_q, state_d;
    fetch_state_e nxt_state;

    logic        busy_q;
    logic        complete_q;
    logic [7:0]  modrm_q;
    logic [15:0] disp_q;
    logic [15:0] imm_q;
    logic [1:0]  disp_len_q;
    logic [1:0]  imm_len_q;
    logic [1:0]  issued_q, issued_d;
    logic        pend_q;

    logic [1:0]  cur_len;
    logic [1:0]  nxt_len;
    logic [1:0]  start_imm_len;
    logic [1:0]  decoded_disp;
    logic [1:0]  issue_len;
    logic [1:0]  issue_cnt;
    logic        start_ok;
    logic        cap;
    logic        in_data_field;
    logic        last_cap;
    logic        advance;
    logic        rd_en;

    logic [1:0]  asm_count;
    logic [15:0] asm_value;

    assign start_imm_len = imm_bytes(imm_size_i);
    assign decoded_disp  = disp_bytes(fifo_rd_data_i);
    assign start_ok      = (state_q == IDLE) && start_i && !flush_i;
    assign cap           = pend_q && !flush_i;
    assign in_data_field = (state_q == DISP) || (state_q == IMM);
    assign last_cap      = cap && ((state_q == MODRM) ||
                                   (in_data_field && ((asm_count + 2'd1) == cur_len)));
    assign advance       = start_ok || last_cap;

    always_comb begin
        cur_len = 2'd0;
        case (state_q)
            MODRM:   cur_len = 2'd1;
            DISP:    cur_len = disp_len_q;
            IMM:     cur_len = imm_len_q;
            default: cur_len = 2'd0;
        endcase
    end

    // Field that follows the current one; after ModRM the length comes straight off the FIFO data.
    always_comb begin
        nxt_state = DONE;
        nxt_len   = 2'd0;
        if (state_q == IDLE) begin
            if (has_modrm_i) begin
                nxt_state = MODRM;
                nxt_len   = 2'd1;
            end else if (start_imm_len != 2'd0) begin
                nxt_state = IMM;
                nxt_len   = start_imm_len;
            end
        end else if (state_q == MODRM) begin
            if (decoded_disp != 2'd0) begin
                nxt_state = DISP;
                nxt_len   = decoded_disp;
            end else if (imm_len_q != 2'd0) begin
                nxt_state = IMM;
                nxt_len   = imm_len_q;
            end
        end else if (state_q == DISP) begin
            if (imm_len_q != 2'd0) begin
                nxt_state = IMM;
                nxt_len   = imm_len_q;
            end
        end
    end

    always_comb begin
        issue_len = advance ? nxt_len : cur_len;
        issue_cnt = advance ? 2'd0 : issued_q;
        rd_en     = (issue_cnt < issue_len) && !fifo_empty_i && !flush_i;

        state_d  = state_q;
        issued_d = issued_q + {1'b0, rd_en};
        if (flush_i) begin
            state_d  = IDLE;
            issued_d = 2'd0;
        end else if (advance) begin
            state_d  = nxt_state;
            issued_d = {1'b0, rd_en};
        end else if (state_q == DONE) begin
            state_d  = IDLE;
            issued_d = 2'd0;
        end
    end

    operand_byte_assembler u_assembler (
        .clk_i     (clk_i),
        .rst_ni    (reset_n_i),
        .clear_i   (flush_i || last_cap || (state_q == IDLE)),
        .capture_i (cap && in_data_field),
        .wide_i    (cur_len == 2'd2),
        .data_i    (fifo_rd_data_i),
        .count_o   (asm_count),
        .value_o   (asm_value)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            modrm_q    <= 8'h00;
            disp_q     <= 16'h0000;
            imm_q      <= 16'h0000;
            disp_len_q <= 2'd0;
            imm_len_q  <= 2'd0;
            issued_q   <= 2'd0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            pend_q     <= rd_en;
            busy_q     <= (state_d != IDLE);
            complete_q <= (state_d == DONE);

            if (start_ok) begin
                modrm_q    <= 8'h00;
                disp_q     <= 16'h0000;
                imm_q      <= 16'h0000;
                disp_len_q <= 2'd0;
                imm_len_q  <= start_imm_len;
            end

            if (cap) begin
                case (state_q)
                    MODRM: begin
                        modrm_q    <= fifo_rd_data_i;
                        disp_len_q <= decoded_disp;
                    end
                    DISP: begin
                        if (last_cap) begin
                            disp_q <= asm_value;
                        end
                    end
                    IMM: begin
                        if (last_cap) begin
                            imm_q <= asm_value;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o         = busy_q;
    assign complete_o     = complete_q;
    assign modrm_o        = modrm_q;
    assign displacement_o = disp_q;
    assign immediate_o    = imm_q;
    assign fifo_rd_en_o   = rd_en;

endmodule
